// File: rtl/exec_writeback_stage.sv
// Execute/write-back stage: runs one latched instruction per start, writes the
// ALU result to memory at Dest, or raises a branch request for BEQ/BNE.
module exec_writeback_stage #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int OP_WIDTH   = 8
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] a_value,
   input  logic [DATA_WIDTH-1:0] b_value,
   input  logic [ADDR_WIDTH-1:0] dest_value,
   input  logic [OP_WIDTH-1:0]   op_value,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_value,
   output logic                  branch_taken,
   output logic [ADDR_WIDTH-1:0] branch_target,
   output logic                  illegal_op,
   output logic                  zero_flag,
   output logic                  carry_flag,
   output logic [1:0]            state_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

   localparam logic [OP_WIDTH-1:0] OP_NOP = 'h00;
   localparam logic [OP_WIDTH-1:0] OP_ADD = 'h01;
   localparam logic [OP_WIDTH-1:0] OP_SUB = 'h02;
   localparam logic [OP_WIDTH-1:0] OP_AND = 'h03;
   localparam logic [OP_WIDTH-1:0] OP_OR  = 'h04;
   localparam logic [OP_WIDTH-1:0] OP_XOR = 'h05;
   localparam logic [OP_WIDTH-1:0] OP_NOT = 'h06;
   localparam logic [OP_WIDTH-1:0] OP_SHL = 'h07;
   localparam logic [OP_WIDTH-1:0] OP_SHR = 'h08;
   localparam logic [OP_WIDTH-1:0] OP_SLT = 'h09;
   localparam logic [OP_WIDTH-1:0] OP_MOV = 'h0A;
   localparam logic [OP_WIDTH-1:0] OP_BEQ = 'h10;
   localparam logic [OP_WIDTH-1:0] OP_BNE = 'h11;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [ADDR_WIDTH-1:0] dest_q, dest_d;
   logic [OP_WIDTH-1:0]   op_q, op_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic                  mem_write_q, mem_write_d;
   logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
   logic [DATA_WIDTH-1:0] mem_write_value_q, mem_write_value_d;
   logic                  branch_taken_q, branch_taken_d;
   logic [ADDR_WIDTH-1:0] branch_target_q, branch_target_d;
   logic                  illegal_op_q, illegal_op_d;
   logic                  zero_flag_q, zero_flag_d, carry_flag_q, carry_flag_d;

   logic [DATA_WIDTH:0]   sum_ext;
   logic [DATA_WIDTH-1:0] alu_res;
   logic                  alu_carry, is_alu, is_branch, br_cond, legal;

   // Decode and compute from the latched operands only.
   always_comb begin
      sum_ext   = {1'b0, a_q} + {1'b0, b_q};
      alu_res   = '0;
      alu_carry = carry_flag_q;
      is_alu    = 1'b1;
      is_branch = 1'b0;
      br_cond   = 1'b0;
      legal     = 1'b1;
      case (op_q)
         OP_ADD: begin
            alu_res   = sum_ext[DATA_WIDTH-1:0];
            alu_carry = sum_ext[DATA_WIDTH];
         end
         OP_SUB: begin
            alu_res   = a_q - b_q;
            alu_carry = (a_q < b_q);
         end
         OP_AND: alu_res = a_q & b_q;
         OP_OR:  alu_res = a_q | b_q;
         OP_XOR: alu_res = a_q ^ b_q;
         OP_NOT: alu_res = ~a_q;
         OP_SHL: alu_res = a_q << b_q[3:0];
         OP_SHR: alu_res = a_q >> b_q[3:0];
         OP_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         OP_MOV: alu_res = a_q;
         OP_NOP: is_alu = 1'b0;
         OP_BEQ: begin
            is_alu    = 1'b0;
            is_branch = 1'b1;
            br_cond   = (a_q == b_q);
         end
         OP_BNE: begin
            is_alu    = 1'b0;
            is_branch = 1'b1;
            br_cond   = (a_q != b_q);
         end
         default: begin
            is_alu = 1'b0;
            legal  = 1'b0;
         end
      endcase
   end

   // Pulse outputs are produced on the transition into the state that owns them,
   // so they are registered yet line up with WRITE/DONE.
   always_comb begin
      state_d           = state_q;
      a_d               = a_q;
      b_d               = b_q;
      dest_d            = dest_q;
      op_d              = op_q;
      mem_address_d     = mem_address_q;
      mem_write_value_d = mem_write_value_q;
      branch_target_d   = branch_target_q;
      zero_flag_d       = zero_flag_q;
      carry_flag_d      = carry_flag_q;
      mem_write_d       = 1'b0;
      done_d            = 1'b0;
      branch_taken_d    = 1'b0;
      illegal_op_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a_value;
               b_d     = b_value;
               dest_d  = dest_value;
               op_d    = op_value;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (is_alu) begin
               zero_flag_d       = (alu_res == '0);
               carry_flag_d      = alu_carry;
               mem_write_d       = 1'b1;
               mem_address_d     = dest_q;
               mem_write_value_d = alu_res;
               state_d           = WRITE;
            end else begin
               done_d       = 1'b1;
               illegal_op_d = ~legal;
               if (is_branch) begin
                  branch_taken_d  = br_cond;
                  branch_target_d = dest_q;
               end
               state_d = DONE;
            end
         end
         WRITE: begin
            done_d  = 1'b1;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q           <= IDLE;
         a_q               <= '0;
         b_q               <= '0;
         dest_q            <= '0;
         op_q              <= '0;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
         mem_write_q       <= 1'b0;
         mem_address_q     <= '0;
         mem_write_value_q <= '0;
         branch_taken_q    <= 1'b0;
         branch_target_q   <= '0;
         illegal_op_q      <= 1'b0;
         zero_flag_q       <= 1'b0;
         carry_flag_q      <= 1'b0;
      end else begin
         state_q           <= state_d;
         a_q               <= a_d;
         b_q               <= b_d;
         dest_q            <= dest_d;
         op_q              <= op_d;
         busy_q            <= busy_d;
         done_q            <= done_d;
         mem_write_q       <= mem_write_d;
         mem_address_q     <= mem_address_d;
         mem_write_value_q <= mem_write_value_d;
         branch_taken_q    <= branch_taken_d;
         branch_target_q   <= branch_target_d;
         illegal_op_q      <= illegal_op_d;
         zero_flag_q       <= zero_flag_d;
         carry_flag_q      <= carry_flag_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign mem_write       = mem_write_q;
   assign mem_address     = mem_address_q;
   assign mem_write_value = mem_write_value_q;
   assign branch_taken    = branch_taken_q;
   assign branch_target   = branch_target_q;
   assign illegal_op      = illegal_op_q;
   assign zero_flag       = zero_flag_q;
   assign carry_flag      = carry_flag_q;
   assign state_dbg       = state_q;

endmodule

// File: tb/tb_exec_writeback_stage.sv
// Directed bench for exec_writeback_stage: vector table of instructions with
// hand-computed writes/flags, plus latching, handshake and reset sequences.
module tb_exec_writeback_stage;

   logic        CLK = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] a_value, b_value, dest_value;
   logic [7:0]  op_value;
   logic        busy, done, mem_write, branch_taken, illegal_op, zero_flag, carry_flag;
   logic [15:0] mem_address, mem_write_value, branch_target;
   logic [1:0]  state_dbg;

   int tests_run = 0;
   int fail_cnt  = 0;
   logic [31:0] exp_q[$];

   exec_writeback_stage dut (
      .CLK(CLK), .reset(reset), .start(start),
      .a_value(a_value), .b_value(b_value), .dest_value(dest_value), .op_value(op_value),
      .busy(busy), .done(done), .mem_write(mem_write), .mem_address(mem_address),
      .mem_write_value(mem_write_value), .branch_taken(branch_taken),
      .branch_target(branch_target), .illegal_op(illegal_op),
      .zero_flag(zero_flag), .carry_flag(carry_flag), .state_dbg(state_dbg)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0]  op;
      logic [15:0] a, b, dest;
      logic        wr;
      logic [15:0] val;
      logic        br, ill, z, c;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_busy"},  busy, 0);
      chk({nm, "_done"},  done, 0);
      chk({nm, "_mw"},    mem_write, 0);
      chk({nm, "_addr"},  mem_address, 0);
      chk({nm, "_data"},  mem_write_value, 0);
      chk({nm, "_br"},    branch_taken, 0);
      chk({nm, "_tgt"},   branch_target, 0);
      chk({nm, "_ill"},   illegal_op, 0);
      chk({nm, "_zf"},    zero_flag, 0);
      chk({nm, "_cf"},    carry_flag, 0);
   endtask

   // Drives one instruction and watches 5 cycles (cycle 1 = after the start edge).
   task automatic run_vec(input vec_t v, input int idx);
      int done_cyc;
      int done_cnt;
      logic [31:0] e;
      string nm;
      nm = $sformatf("v%0d", idx);
      done_cyc = 0;
      done_cnt = 0;
      @(negedge CLK);
      a_value = v.a; b_value = v.b; dest_value = v.dest; op_value = v.op; start = 1'b1;
      if (v.wr) exp_q.push_back({v.dest, v.val});
      for (int c = 1; c <= 5; c++) begin
         @(posedge CLK); #1;
         if (c == 1) begin
            start = 1'b0;
            chk({nm, "_busy_exec"}, busy, 1);
         end
         if (mem_write) begin
            chk({nm, "_wr_cycle"}, c, 2);
            if (exp_q.size() == 0) chk({nm, "_unexpected_wr"}, 1, 0);
            else begin
               e = exp_q.pop_front();
               chk({nm, "_wr_addr"}, mem_address, e[31:16]);
               chk({nm, "_wr_data"}, mem_write_value, e[15:0]);
            end
         end
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
            chk({nm, "_branch"}, branch_taken, v.br);
            if (v.br) chk({nm, "_target"}, branch_target, v.dest);
            chk({nm, "_illegal"}, illegal_op, v.ill);
         end else begin
            chk({nm, "_stray_pulse"}, {branch_taken, illegal_op}, 0);
         end
      end
      chk({nm, "_done_cycle"}, done_cyc, v.wr ? 3 : 2);
      chk({nm, "_done_count"}, done_cnt, 1);
      chk({nm, "_missing_wr"}, exp_q.size(), 0);
      exp_q.delete();
      chk({nm, "_zero_flag"}, zero_flag, v.z);
      chk({nm, "_carry_flag"}, carry_flag, v.c);
      chk({nm, "_idle"}, busy, 0);
   endtask

   vec_t vecs[20];
   vec_t shl_v;

   initial begin
      int wr_cnt;
      //            op     a        b        dest     wr  val      br ill z  c
      vecs[0]  = '{8'h01, 16'hFFFF, 16'h0001, 16'h0010, 1, 16'h0000, 0, 0, 1, 1};
      vecs[1]  = '{8'h02, 16'd5,    16'd7,    16'd42069,1, 16'hFFFE, 0, 0, 0, 1};
      vecs[2]  = '{8'h03, 16'h00FF, 16'h0F0F, 16'h0020, 1, 16'h000F, 0, 0, 0, 1};
      vecs[3]  = '{8'h10, 16'h1234, 16'h1234, 16'h0200, 0, 16'h0000, 1, 0, 0, 1};
      vecs[4]  = '{8'h10, 16'h1234, 16'h1235, 16'h0200, 0, 16'h0000, 0, 0, 0, 1};
      vecs[5]  = '{8'h42, 16'h0000, 16'h0000, 16'h0050, 0, 16'h0000, 0, 1, 0, 1};
      vecs[6]  = '{8'h04, 16'h0F00, 16'h00F0, 16'h0030, 1, 16'h0FF0, 0, 0, 0, 1};
      vecs[7]  = '{8'h05, 16'hAAAA, 16'hAAAA, 16'h0031, 1, 16'h0000, 0, 0, 1, 1};
      vecs[8]  = '{8'h06, 16'h0000, 16'h1234, 16'h0032, 1, 16'hFFFF, 0, 0, 0, 1};
      vecs[9]  = '{8'h07, 16'h0001, 16'h0013, 16'h0033, 1, 16'h0008, 0, 0, 0, 1};
      vecs[10] = '{8'h08, 16'h8000, 16'h000F, 16'h0034, 1, 16'h0001, 0, 0, 0, 1};
      vecs[11] = '{8'h09, 16'h8000, 16'h0001, 16'h0035, 1, 16'h0001, 0, 0, 0, 1};
      vecs[12] = '{8'h09, 16'h0001, 16'h8000, 16'h0036, 1, 16'h0000, 0, 0, 1, 1};
      vecs[13] = '{8'h0A, 16'h1234, 16'h0000, 16'h0037, 1, 16'h1234, 0, 0, 0, 1};
      vecs[14] = '{8'h01, 16'h0001, 16'h0002, 16'h0038, 1, 16'h0003, 0, 0, 0, 0};
      vecs[15] = '{8'h00, 16'h0000, 16'h0000, 16'h0060, 0, 16'h0000, 0, 0, 0, 0};
      vecs[16] = '{8'h11, 16'h0001, 16'h0002, 16'h0300, 0, 16'h0000, 1, 0, 0, 0};
      vecs[17] = '{8'h02, 16'h0007, 16'h0007, 16'h0039, 1, 16'h0000, 0, 0, 1, 0};
      vecs[18] = '{8'h02, 16'h0000, 16'h0001, 16'h003A, 1, 16'hFFFF, 0, 0, 0, 1};
      vecs[19] = '{8'h11, 16'h0005, 16'h0005, 16'h0400, 0, 16'h0000, 0, 0, 0, 1};
      shl_v    = '{8'h07, 16'h0001, 16'h0013, 16'h0077, 1, 16'h0008, 0, 0, 0, 0};

      // clock/reset
      reset = 1'b1; start = 1'b0;
      a_value = '0; b_value = '0; dest_value = '0; op_value = '0;
      repeat (3) @(posedge CLK);
      #1 chk_all_zero("reset");
      @(negedge CLK) reset = 1'b0;

      for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

      // Inputs change and start is held after acceptance: exactly one write of 7 to 45.
      wr_cnt = 0;
      @(negedge CLK);
      a_value = 16'd3; b_value = 16'd4; dest_value = 16'd45; op_value = 8'h01; start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge CLK); #1;
         if (c == 1) a_value = 16'd100;
         if (c == 3) start = 1'b0;
         if (mem_write) begin
            wr_cnt++;
            chk("hold_wr_addr", mem_address, 16'd45);
            chk("hold_wr_data", mem_write_value, 16'd7);
         end
         if (c == 3) chk("hold_done_c3", done, 1);
         if (c >= 4) chk("hold_no_requeue", busy, 0);
      end
      chk("hold_wr_count", wr_cnt, 1);
      // Second instruction starts from IDLE with the updated operand (100+4).
      run_vec('{8'h01, 16'd100, 16'd4, 16'd46, 1, 16'd104, 0, 0, 0, 0}, 100);

      // Reset during EXEC of an ALU op: no write, outputs clear immediately.
      wr_cnt = 0;
      @(negedge CLK);
      a_value = 16'h0010; b_value = 16'h0020; dest_value = 16'h0099; op_value = 8'h01; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      chk("rst_busy_before", busy, 1);
      reset = 1'b1;
      #1 chk_all_zero("rst_async");
      for (int c = 0; c < 3; c++) begin
         @(posedge CLK); #1;
         if (mem_write || done) wr_cnt++;
      end
      @(negedge CLK) reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge CLK); #1;
         if (mem_write || done) wr_cnt++;
      end
      chk("rst_no_retire", wr_cnt, 0);
      run_vec(shl_v, 200);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
